// File: rtl/cpu_pkg.sv
// Shared pipeline types for the 5-stage CPU: forwarding selects and
// the control metadata shadowed in each inter-stage register.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ldur;
    logic              sf;
  } idex_meta_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ldur;
  } exmem_meta_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
  } memwb_meta_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: shadows control bits of in-flight instructions and
// produces stall, bubble, flush and forwarding selects for the 5-stage CPU.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW   = cpu_pkg::REG_AW,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_ldur,
  input  logic              id_set_flags,
  input  logic              id_reg_br,
  input  logic              id_br_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        id_fwd,
  output logic              flag_fwd,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [REG_AW-1:0] XZR = REG_AW'(ZERO_REG);

  idex_meta_t  idex_p0, idex_nxt;
  exmem_meta_t exmem_p1;
  memwb_meta_t memwb_p2;
  logic        stall, stall_a, stall_b, stall_c, flush;

  function automatic logic hit(input logic rw, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] x);
    return rw && (rd == x);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic wb_hit);
    if (ex_hit)      return FWD_EXMEM;
    else if (wb_hit) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

  always_comb begin
    // Branch registers are resolved in ID, so a producer still in EX (or a
    // load still in MEM) cannot supply them in time.
    stall_a = idex_p0.ldur &&
              ((id_use_rn && hit(idex_p0.rw, idex_p0.rd, id_rn)) ||
               (id_use_rm && hit(idex_p0.rw, idex_p0.rd, id_rm)));
    stall_b = id_reg_br && hit(idex_p0.rw, idex_p0.rd, id_rm);
    stall_c = id_reg_br && exmem_p1.ldur && hit(exmem_p1.rw, exmem_p1.rd, id_rm);
    stall   = !reset && id_valid && (stall_a || stall_b || stall_c);
    flush   = !reset && id_valid && id_br_taken && !stall;

    idex_nxt = '0;
    if (id_valid && !stall) begin
      idex_nxt.rn   = id_rn;
      idex_nxt.rm   = id_rm;
      idex_nxt.rd   = id_rd;
      idex_nxt.rw   = id_reg_write && (id_rd != XZR);
      idex_nxt.ldur = id_ldur;
      idex_nxt.sf   = id_set_flags;
    end
  end

  assign pc_en       = !stall;
  assign ifid_en     = !stall;
  assign idex_bubble = stall;
  assign ifid_flush  = flush;
  assign flag_fwd    = idex_p0.sf;
  assign fwd_a  = fwd_pick(hit(exmem_p1.rw, exmem_p1.rd, idex_p0.rn) && !exmem_p1.ldur,
                           hit(memwb_p2.rw, memwb_p2.rd, idex_p0.rn));
  assign fwd_b  = fwd_pick(hit(exmem_p1.rw, exmem_p1.rd, idex_p0.rm) && !exmem_p1.ldur,
                           hit(memwb_p2.rw, memwb_p2.rd, idex_p0.rm));
  assign id_fwd = fwd_pick(hit(exmem_p1.rw, exmem_p1.rd, id_rm),
                           hit(memwb_p2.rw, memwb_p2.rd, id_rm));

  // ID -> EX -> MEM -> WB metadata advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_p0  <= '0;
      exmem_p1 <= '0;
      memwb_p2 <= '0;
    end else begin
      idex_p0  <= idex_nxt;
      exmem_p1 <= '{rd: idex_p0.rd, rw: idex_p0.rw, ldur: idex_p0.ldur};
      memwb_p2 <= '{rd: exmem_p1.rd, rw: exmem_p1.rw};
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .count(stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_reg_write, id_ldur, id_set_flags;
  logic        id_reg_br, id_br_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, flag_fwd;
  logic [1:0]  fwd_a, fwd_b, id_fwd;
  logic [15:0] stall_count, flush_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  hazard_ctrl #(.REG_AW(5), .ZERO_REG(31), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_ldur(id_ldur), .id_set_flags(id_set_flags),
    .id_reg_br(id_reg_br), .id_br_taken(id_br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_fwd(id_fwd), .flag_fwd(flag_fwd), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // valid, rn, rm, use_rn, use_rm, rd, reg_write, ldur, set_flags, reg_br, br_taken
  task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic sf,
                        input logic rbr, input logic tk);
    id_valid = v; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
    id_rd = rd; id_reg_write = rw; id_ldur = ld; id_set_flags = sf;
    id_reg_br = rbr; id_br_taken = tk;
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic s);
    check_vec({tag, ".pc_en"}, pc_en, !s);
    check_vec({tag, ".ifid_en"}, ifid_en, !s);
    check_vec({tag, ".bubble"}, idex_bubble, s);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_stall("rst", 0);
    check_vec("rst.flush", ifid_flush, 0);
    check_vec("rst.fwd", {fwd_a, fwd_b, id_fwd}, 0);
    check_vec("rst.flag", flag_fwd, 0);
    check_vec("rst.cnt", {stall_count, flush_count}, 0);
    reset = 1'b0;
    tick();

    // LDUR X1,[X9] ; ADDS X2,X1,X3
    set_id(1, 9, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    check_stall("t1.ldur", 0);
    tick();
    set_id(1, 1, 3, 1, 1, 2, 1, 0, 1, 0, 0);
    check_stall("t1.use", 1);
    tick();
    check_stall("t1.after", 0);
    tick();
    idle();
    check_vec("t1.fwd_a", fwd_a, 2'b10);
    check_vec("t1.fwd_b", fwd_b, 2'b00);
    check_vec("t1.flag", flag_fwd, 1);
    check_vec("t1.scnt", stall_count, 1);
    tick(); tick(); tick();

    // ADDI X4,X5 ; CBZ X4 (taken)
    set_id(1, 5, 0, 1, 0, 4, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 4, 0, 1, 0, 0, 0, 0, 1, 1);
    check_stall("t2a.stall", 1);
    check_vec("t2a.noflush", ifid_flush, 0);
    tick();
    check_stall("t2a.go", 0);
    check_vec("t2a.id_fwd", id_fwd, 2'b01);
    check_vec("t2a.flush", ifid_flush, 1);
    tick();
    idle();
    check_vec("t2a.scnt", stall_count, 2);
    check_vec("t2a.fcnt", flush_count, 1);
    tick(); tick(); tick();

    // LDUR X4 ; CBZ X4 (not taken)
    set_id(1, 9, 0, 1, 0, 4, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 0, 4, 0, 1, 0, 0, 0, 0, 1, 0);
    check_stall("t2b.s1", 1);
    tick();
    check_stall("t2b.s2", 1);
    tick();
    check_stall("t2b.go", 0);
    check_vec("t2b.id_fwd", id_fwd, 2'b10);
    tick();
    idle();
    check_vec("t2b.scnt", stall_count, 4);
    tick(); tick(); tick();

    // SUBS X6,X7,X8 ; B.LT taken
    set_id(1, 7, 8, 1, 1, 6, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_vec("t3.flag", flag_fwd, 1);
    check_stall("t3", 0);
    check_vec("t3.flush", ifid_flush, 1);
    tick();
    idle();
    check_vec("t3.flush_off", ifid_flush, 0);
    check_vec("t3.fcnt", flush_count, 2);
    check_vec("t3.scnt", stall_count, 4);
    tick(); tick(); tick();

    // LDUR X31 ; ADDS X31,X1,X2 ; ADDS X3,X31,X31
    set_id(1, 9, 0, 1, 0, 31, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 1, 2, 1, 1, 31, 1, 0, 1, 0, 0);
    check_stall("t4.ldxzr", 0);
    tick();
    set_id(1, 31, 31, 1, 1, 3, 1, 0, 1, 0, 0);
    check_stall("t4.use", 0);
    tick();
    idle();
    check_vec("t4.fwd", {fwd_a, fwd_b}, 4'b0000);
    tick(); tick(); tick();

    // ADD X5 ; ADD X5 ; ADD X10,X5,X5
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 0);
    tick();
    idle();
    check_vec("t5.fwd_a", fwd_a, 2'b01);
    check_vec("t5.fwd_b", fwd_b, 2'b01);
    tick(); tick(); tick();

    // reset asserted in the middle of a load-use stall
    set_id(1, 9, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 1);
    check_stall("t6.pre", 1);
    reset = 1'b1;
    #1;
    check_stall("t6.rst", 0);
    check_vec("t6.flush", ifid_flush, 0);
    check_vec("t6.fwd", {fwd_a, fwd_b, id_fwd}, 0);
    check_vec("t6.cnt", {stall_count, flush_count}, 0);
    tick();
    set_id(1, 1, 0, 1, 0, 2, 1, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_stall("t6.rel", 0);
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(12 + 3 * i), 5'(13 + 3 * i), 1, 1, 5'(20 + i), 1, 0, 0, 0, 0);
      check_stall($sformatf("t6.s%0d", i), 0);
      check_vec($sformatf("t6.fwd%0d", i), {fwd_a, fwd_b, id_fwd}, 0);
      tick();
    end
    idle();
    check_vec("t6.scnt", stall_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
